// File: rtl/div_if.sv
// Handshake and result bundle between the execute-stage control and the divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             annul;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_div, opa, opb, annul,
    input  busy, stall_req, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div, opa, opb, annul,
    output busy, stall_req, done, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// quotient goes to LO and remainder to HI, with a one-cycle done pulse.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] dvd_p0;     // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_p0;     // divisor magnitude
  logic [WIDTH-1:0] prem_p0;    // partial remainder
  logic [CNT_W-1:0] cnt_p0;
  logic             sign_q_p0;
  logic             sign_r_p0;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;

  logic             idle_or_done;
  logic             accept;
  logic             by_zero;
  logic             last;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

  // Conditional negation used for the final sign fix.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign accept       = bus.start && !bus.annul && idle_or_done;
  assign by_zero      = (bus.opb == '0);
  assign last         = (cnt_p0 == CNT_W'(WIDTH - 1));

  // Trial subtraction is one bit wider than the operands so the borrow is the sign.
  assign trial    = {prem_p0, dvd_p0[WIDTH-1]} - {1'b0, dvs_p0};
  assign qbit     = ~trial[WIDTH];
  assign prem_nxt = qbit ? trial[WIDTH-1:0] : {prem_p0[WIDTH-2:0], dvd_p0[WIDTH-1]};
  assign dvd_nxt  = {dvd_p0[WIDTH-2:0], qbit};

  // Next-state decode; annul wins over both issue and completion.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = by_zero ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      RUN: begin
        if (bus.annul) state_nxt = IDLE;
        else if (last) state_nxt = DONE;
        else           state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt == RUN);
      done_r <= (state_nxt == DONE);
    end
  end

  // ---- stage p0: operand capture and one restoring iteration per cycle ----
  // Iteration datapath, plus result registers that only change on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_p0    <= '0;
      dvs_p0    <= '0;
      prem_p0   <= '0;
      cnt_p0    <= '0;
      sign_q_p0 <= 1'b0;
      sign_r_p0 <= 1'b0;
      quo_r     <= '0;
      rem_r     <= '0;
    end else if (accept) begin
      if (by_zero) begin
        quo_r <= '1;
        rem_r <= bus.opa;
      end else begin
        dvd_p0    <= magnitude(bus.opa, bus.signed_div);
        dvs_p0    <= magnitude(bus.opb, bus.signed_div);
        prem_p0   <= '0;
        cnt_p0    <= '0;
        sign_q_p0 <= bus.signed_div && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
        sign_r_p0 <= bus.signed_div && bus.opa[WIDTH-1];
      end
    end else if ((state == RUN) && !bus.annul) begin
      dvd_p0  <= dvd_nxt;
      prem_p0 <= prem_nxt;
      cnt_p0  <= cnt_p0 + CNT_W'(1);
      // ---- stage p1: sign fix lands on the edge that enters DONE ----
      if (last) begin
        quo_r <= neg_if(dvd_nxt, sign_q_p0);
        rem_r <= neg_if(prem_nxt, sign_r_p0);
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
  assign bus.stall_req = busy_r || accept;

endmodule
